// File: rtl/nonce_collector.sv
// rtl/nonce_collector.sv - FIFO of winning nonces behind the compare stage
//
// Purpose: counts compare results to recover each result's nonce, queues every
// winning nonce tagged with a sequence number, and presents the head entry
// (CRC-protected) to the host, which pops entries by toggling pop_toggle.
//
// Ports:
//   clk         in   miner clock, rising edge
//   sys_rst     in   asynchronous active-high reset
//   has_res     in   compare result strobe, one result per high cycle
//   res         in   compare result, 1 = hash below target
//   new_work    in   single-cycle pulse, header or target changed
//   pop_toggle  in   host pop request, one pop per level change (async to clk)
//   head_word   out  {crc12(nonce), nonce} of the head entry
//   head_seq    out  sequence tag of the head entry
//   head_valid  out  head_word/head_seq are valid
//   count       out  FIFO occupancy, 0..DEPTH
//   overflow    out  sticky, a hit was dropped on a full FIFO

module nonce_collector #(
   parameter int          DEPTH       = 8,
   parameter logic [31:0] INONCE      = 32'd0,
   parameter int          SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        sys_rst,
   input  logic        has_res,
   input  logic        res,
   input  logic        new_work,
   input  logic        pop_toggle,
   output logic [43:0] head_word,
   output logic [7:0]  head_seq,
   output logic        head_valid,
   output logic [6:0]  count,
   output logic        overflow
);

   localparam int AW = $clog2(DEPTH);

   logic [39:0]            mem [DEPTH];
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;
   logic [31:0]            nonce_cnt;
   logic [7:0]             seq;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   edge_q;

   logic        pop_evt;
   logic        empty;
   logic        full;
   logic        hit;
   logic        do_pop;
   logic        do_push;
   logic        drop;
   logic [39:0] head_entry;

   // CRC-12, polynomial 0x80F, zero init, MSB first, no reflection.
   function automatic logic [11:0] crc12(input logic [31:0] data);
      logic [11:0] c;
      logic        fb;
      c = 12'h000;
      for (int i = 31; i >= 0; i--) begin
         fb = c[11] ^ data[i];
         c  = {c[10:0], 1'b0} ^ (fb ? 12'h80F : 12'h000);
      end
      return c;
   endfunction

   assign pop_evt = sync_q[SYNC_STAGES-1] ^ edge_q;
   assign empty   = (count == 7'd0);
   assign full    = (count == 7'(DEPTH));

   // new_work outranks everything: any push or pop on its edge is discarded.
   assign hit     = has_res & res & ~new_work;
   assign do_pop  = pop_evt & ~empty & ~new_work;
   // A pop on the same edge frees the slot, so a hit on a full FIFO still lands.
   assign do_push = hit & (~full | do_pop);
   assign drop    = hit & full & ~do_pop;

   assign head_entry = mem[rd_ptr];

   // Storage has no reset; only entries between rd_ptr and wr_ptr are ever read.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= {seq, nonce_cnt};
      end
   end

   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         sync_q <= '0;
         edge_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pop_toggle};
         edge_q <= sync_q[SYNC_STAGES-1];
      end
   end

   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         nonce_cnt <= INONCE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= 7'd0;
         seq       <= 8'd0;
         overflow  <= 1'b0;
      end else if (new_work) begin
         // seq deliberately survives so the host can see gaps across work.
         nonce_cnt <= INONCE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= 7'd0;
         overflow  <= 1'b0;
      end else begin
         if (has_res) begin
            nonce_cnt <= nonce_cnt + 32'd1;
         end
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
            seq    <= seq + 8'd1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (drop) begin
            overflow <= 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 7'd1;
         end else if (do_pop && !do_push) begin
            count <= count - 7'd1;
         end
      end
   end

   // Head is sampled from the FIFO state one edge behind; the CRC sits off the
   // FIFO read path this way. Contents hold while the FIFO is empty.
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         head_word  <= 44'd0;
         head_seq   <= 8'd0;
         head_valid <= 1'b0;
      end else begin
         head_valid <= ~empty;
         if (!empty) begin
            head_word <= {crc12(head_entry[31:0]), head_entry[31:0]};
            head_seq  <= head_entry[39:32];
         end
      end
   end

endmodule

// File: tb/tb_nonce_collector.sv
// tb/tb_nonce_collector.sv - scoreboard bench for nonce_collector
module tb_nonce_collector;

   localparam int DEPTH = 8;
   localparam int SYNC  = 2;

   logic clk = 1'b0;
   logic sys_rst, has_res, res, new_work, pop_toggle;
   logic [43:0] head_word_a, head_word_b;
   logic [7:0]  head_seq_a, head_seq_b;
   logic        head_valid_a, head_valid_b;
   logic [6:0]  count_a, count_b;
   logic        overflow_a, overflow_b;

   nonce_collector #(.DEPTH(DEPTH), .INONCE(32'h0000_0000), .SYNC_STAGES(SYNC)) dut_a (
      .clk(clk), .sys_rst(sys_rst), .has_res(has_res), .res(res), .new_work(new_work),
      .pop_toggle(pop_toggle), .head_word(head_word_a), .head_seq(head_seq_a),
      .head_valid(head_valid_a), .count(count_a), .overflow(overflow_a));

   nonce_collector #(.DEPTH(DEPTH), .INONCE(32'hFFFF_FFFE), .SYNC_STAGES(SYNC)) dut_b (
      .clk(clk), .sys_rst(sys_rst), .has_res(has_res), .res(res), .new_work(new_work),
      .pop_toggle(pop_toggle), .head_word(head_word_b), .head_seq(head_seq_b),
      .head_valid(head_valid_b), .count(count_b), .overflow(overflow_b));

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  seq;
      logic [31:0] nonce;
   } ent_t;

   int errors = 0;
   int checks = 0;

   ent_t        fifo[$];
   ent_t        exp_q[$];
   int          pop_due[$];
   logic [31:0] m_nonce;
   logic [7:0]  m_seq;
   logic        m_ovf;
   int          m_prev_size;
   int          cyc = 0;
   int          last_toggle = -100;

   // CRC as remainder of (nonce * x^12) mod (x^12+x^11+x^3+x^2+x+1).
   function automatic logic [11:0] crc_ref(input logic [31:0] n);
      logic [43:0] r;
      r = {n, 12'h000};
      for (int i = 43; i >= 12; i--) begin
         if (r[i]) r[i -: 13] = r[i -: 13] ^ 13'h180F;
      end
      return r[11:0];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      fifo.delete();
      exp_q.delete();
      pop_due.delete();
      m_nonce     = 32'd0;
      m_seq       = 8'd0;
      m_ovf       = 1'b0;
      m_prev_size = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      sys_rst    = 1'b1;
      has_res    = 1'b0;
      res        = 1'b0;
      new_work   = 1'b0;
      pop_toggle = 1'b0;
      model_reset();
      #1;
      chk("rst_count", count_a, 0);
      chk("rst_overflow", overflow_a, 0);
      chk("rst_head_valid", head_valid_a, 0);
      chk("rst_head_word", head_word_a, 0);
      chk("rst_head_seq", head_seq_a, 0);
      @(negedge clk);
      sys_rst = 1'b0;
   endtask

   // One clock: drive at negedge, advance the reference at the edge, check after.
   task automatic step(input logic hr, input logic r, input logic nw, input logic tg);
      bit   pop_now;
      bit   hv_exp;
      ent_t e;
      @(negedge clk);
      has_res  = hr;
      res      = r;
      new_work = nw;
      if (tg) begin
         pop_toggle = ~pop_toggle;
         pop_due.push_back(cyc + SYNC);
         last_toggle = cyc;
      end
      @(posedge clk);
      pop_now = 0;
      while (pop_due.size() > 0 && pop_due[0] <= cyc) begin
         void'(pop_due.pop_front());
         pop_now = 1;
      end
      if (nw) begin
         // The entry at the front may still be shown once, one edge late.
         if (exp_q.size() > 0 && fifo.size() > 0 && exp_q[0] == fifo[0]) begin
            e = exp_q[0];
            exp_q.delete();
            exp_q.push_back(e);
         end else begin
            exp_q.delete();
         end
         fifo.delete();
         m_ovf   = 1'b0;
         m_nonce = 32'd0;
      end else begin
         if (pop_now && fifo.size() > 0) void'(fifo.pop_front());
         if (hr && r) begin
            if (fifo.size() < DEPTH) begin
               e.seq   = m_seq;
               e.nonce = m_nonce;
               fifo.push_back(e);
               exp_q.push_back(e);
               m_seq++;
            end else begin
               m_ovf = 1'b1;
            end
         end
         if (hr) m_nonce++;
      end
      hv_exp      = (m_prev_size > 0);
      m_prev_size = fifo.size();
      cyc++;
      #1;
      chk("count_a", count_a, fifo.size());
      chk("count_b", count_b, fifo.size());
      chk("overflow_a", overflow_a, m_ovf);
      chk("overflow_b", overflow_b, m_ovf);
      chk("head_valid_a", head_valid_a, hv_exp);
      chk("head_valid_b", head_valid_b, hv_exp);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while ((fifo.size() > 0 || m_prev_size > 0) && guard < 80) begin
         step(0, 0, 0, 1);
         idle(8);
         guard++;
      end
      idle(3);
      chk("drained", count_a, 0);
   endtask

   // Monitor: each newly presented head entry is matched against the scoreboard.
   logic       last_v = 1'b0;
   logic [7:0] last_s = 8'd0;
   ent_t       mon_e;
   logic [31:0] nb;

   always @(negedge clk) begin
      if (sys_rst !== 1'b0) begin
         last_v = 1'b0;
      end else begin
         if (head_valid_a && (!last_v || head_seq_a != last_s)) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL head_unexpected: got seq %0h word %0h expected none", head_seq_a, head_word_a);
            end else begin
               mon_e = exp_q.pop_front();
               nb    = mon_e.nonce + 32'hFFFF_FFFE;
               chk("head_seq_a", head_seq_a, mon_e.seq);
               chk("head_word_a", head_word_a, {crc_ref(mon_e.nonce), mon_e.nonce});
               chk("head_seq_b", head_seq_b, mon_e.seq);
               chk("head_word_b", head_word_b, {crc_ref(nb), nb});
            end
         end
         last_v = head_valid_a;
         last_s = head_seq_a;
      end
   end

   initial begin
      sys_rst    = 1'b1;
      has_res    = 1'b0;
      res        = 1'b0;
      new_work   = 1'b0;
      pop_toggle = 1'b0;
      model_reset();

      // res = 0,0,1 -> single entry with nonce 2, seq 0
      do_reset();
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      idle(3);

      // 10 hits into depth 8: overflow, then drain nonces 0..7
      do_reset();
      for (int i = 0; i < 10; i++) step(1, 1, 0, 0);
      idle(2);
      drain();

      // Full FIFO with a pop landing on the same edge as a hit
      for (int i = 0; i < 8; i++) step(1, 1, 0, 0);
      idle(9);
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
      step(1, 1, 0, 0);
      idle(3);
      drain();

      // Pop on empty FIFO is ignored; later hit stores normally
      step(0, 0, 0, 1);
      idle(8);
      step(1, 1, 0, 0);
      idle(3);
      drain();

      // new_work with 3 queued entries and a hit on the same edge
      do_reset();
      for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
      idle(3);
      step(1, 1, 1, 0);
      step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      idle(3);
      drain();

      // Reset while a pop is still in the synchronizer
      do_reset();
      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      idle(2);
      step(0, 0, 0, 1);
      do_reset();
      step(1, 1, 0, 0);
      idle(4);
      drain();

      // Randomized traffic; enough accepted pushes to wrap seq past 255
      for (int i = 0; i < 5000; i++) begin
         step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 199) == 0),
              ((cyc - last_toggle) >= 9) && ($urandom_range(0, 2) == 0));
      end
      idle(9);
      drain();
      chk("all_presented", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
